game_timer: RTL and testbench
=============================

Name: game_timer

Overview:
- Upstream feeder for the end-of-level result screen, which draws the "TIME TAKEN" and "BEST TIME" labels on the 96x64 OLED.
- Measures level play time in 0.1 s steps as 4 packed BCD digits (ddd.d, 000.0–999.9 s).
- Tracks the session best (lowest) time and flags a new best.
- Result screen renders digits straight from time_bcd / best_bcd.

Parameters:
- CLK_HZ, 6250000, frequency of clk in Hz.
- TICK_HZ, 10, timer resolution in ticks per second; CLK_HZ must be an integer multiple of TICK_HZ.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous and active-low.
- start  in  1  one-cycle pulse: level begins.
- stop  in  1  one-cycle pulse: level completed.
- abort  in  1  one-cycle pulse: level quit without completing.
- time_bcd  out  16  current/final time: [15:12]=hundreds s, [11:8]=tens s, [7:4]=units s, [3:0]=tenths.
- best_bcd  out  16  best completed time, same format.
- best_valid  out  1  best_bcd holds a real result.
- new_best  out  1  last completed run set a new best.
- running  out  1  timer in RUN state.
- done  out  1  timer in DONE state; result screen may be shown.
- overflow  out  1  time saturated at 999.9.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, prescaler=0.
  - time_bcd=16'h0000, best_bcd=16'h9999.
  - best_valid=0, new_best=0, running=0, done=0, overflow=0.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 while in RUN; tick asserts on the wrap cycle.
- States:
  - IDLE:
    - start -> RUN on the next edge.
    - time_bcd, prescaler, overflow, new_best cleared on that same edge.
  - RUN:
    - On tick: increment time_bcd as a cascaded decimal counter (tenths wrap 9->0 carrying to units, and so on).
    - At 16'h9999 the value holds and overflow=1.
    - stop -> DONE.
    - abort -> IDLE: time_bcd cleared, best untouched.
    - start is ignored.
  - DONE:
    - time_bcd frozen.
    - start -> RUN: clears as in IDLE, including new_best.
    - abort -> IDLE: clears time_bcd and new_best.
- Best update, evaluated on the stop edge using the frozen time:
  - Condition: best_valid==0, or time_bcd < best_bcd (nibble-wise BCD compare, MSD first; equivalent to unsigned compare of the 16-bit word).
  - Action: best_bcd<=time_bcd, best_valid<=1, new_best<=1.
  - best_bcd and new_best are visible in the first DONE cycle.
  - Equal times do not set new_best.
- Simultaneous events:
  - stop+abort in RUN: stop wins.
  - tick in the stop cycle is discarded.
  - start+stop in RUN: stop wins.
  - start+abort in DONE: start wins.
- Outputs are registered; running and done decode the state register.
- Reset mid-RUN: full reset, best lost.

Optional Feature:
- Macro: GAME_TIMER_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit, level).
  - While pause=1 in RUN, the prescaler and digits hold.
  - stop and abort are still honoured.
  - Resuming continues from the held prescaler value, so no partial tick is lost.
- Undefined:
  - No pause port.
  - Timer runs continuously in RUN.

Decomposition:
- Package game_timer_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - bcd_t (4-bit) and time_bcd_t (16-bit) typedefs;
  - constants TIME_MAX=16'h9999, TIME_ZERO=16'h0000.
- Sub-module bcd_digit:
  - one decade counter with clr, inc (carry in) and carry out (digit==9 && inc);
  - game_timer instantiates four of them.

Test Plan (CLK_HZ=100, TICK_HZ=10, so 10 cycles per tick):
- Reset then idle 50 cycles -> time_bcd=0000, best_bcd=9999, best_valid=0, all flags 0.
- start; run 125 cycles; stop -> time_bcd=0012 frozen, done=1, best_bcd=0012, best_valid=1, new_best=1 in the first DONE cycle.
- Second run of 200 cycles then stop -> time_bcd=0020, best_bcd stays 0012, new_best=0. Third run of 80 cycles -> best_bcd=0008, new_best=1.
- Carry chain: preload via run to 0099 (990 cycles) then one more tick -> 0100. Force 9999 -> holds 9999, overflow=1.
- Abort in RUN at 0005 -> IDLE, time_bcd=0000, best unchanged. stop+abort same cycle -> DONE, best updated.
- rst_n=0 for one cycle mid-RUN -> all outputs at reset values on the next edge. With GAME_TIMER_PAUSE_EN defined: pause for 50 cycles mid-run -> final time 50 cycles (5 ticks) shorter than the unpaused run.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and constants for the level play timer.
package game_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic [3:0]  bcd_t;
  typedef logic [15:0] time_bcd_t;

  localparam time_bcd_t TIME_MAX  = 16'h9999;
  localparam time_bcd_t TIME_ZERO = 16'h0000;

  // Packed BCD orders exactly like unsigned binary, so a plain compare suffices.
  function automatic logic time_less(input time_bcd_t a, input time_bcd_t b);
    return a < b;
  endfunction

endpackage

// File: rtl/game_timer_bcd_digit.sv
// One decade (0..9) counter stage of the cascaded BCD time counter.
// clr has priority over inc; carry is combinational from inc and the held digit.
module bcd_digit
  import game_timer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t digit,
  output logic carry
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

  assign carry = inc && (digit == 4'd9);

endmodule

// File: rtl/game_timer.sv
// Level play timer in 0.1 s BCD steps with session best tracking.
// Optional macro GAME_TIMER_PAUSE_EN adds a level-sensitive pause input.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ  = 6250000,
  parameter int TICK_HZ = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  logic      stop,
  input  logic      abort,
`ifdef GAME_TIMER_PAUSE_EN
  input  logic      pause,
`endif
  output time_bcd_t time_bcd,
  output time_bcd_t best_bcd,
  output logic      best_valid,
  output logic      new_best,
  output logic      running,
  output logic      done,
  output logic      overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  state_t        state;
  logic [PW-1:0] presc;
  logic          hold;
  logic          in_run;
  logic          tick;
  logic          clr;
  logic          inc0;
  logic [3:1]    carry;
  logic          msd_carry_unused;

`ifdef GAME_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign in_run = (state == RUN);
  assign tick   = in_run && !hold && (presc == PW'(DIV - 1));

  // Digits clear on any start out of IDLE/DONE and on any honoured abort.
  assign clr = ((state == IDLE) && start)
             || ((state == DONE) && (start || abort))
             || (in_run && abort && !stop);

  // A tick coinciding with stop is dropped so the stopped value is final.
  assign inc0 = tick && !stop && (time_bcd != TIME_MAX);

  bcd_digit u_tenths (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc0),
                      .digit(time_bcd[3:0]),   .carry(carry[1]));
  bcd_digit u_units  (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry[1]),
                      .digit(time_bcd[7:4]),   .carry(carry[2]));
  bcd_digit u_tens   (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry[2]),
                      .digit(time_bcd[11:8]),  .carry(carry[3]));
  bcd_digit u_hunds  (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry[3]),
                      .digit(time_bcd[15:12]), .carry(msd_carry_unused));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      best_bcd   <= TIME_MAX;
      best_valid <= 1'b0;
      new_best   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            presc    <= '0;
            overflow <= 1'b0;
            new_best <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= DONE;
            if (!best_valid || time_less(time_bcd, best_bcd)) begin
              best_bcd   <= time_bcd;
              best_valid <= 1'b1;
              new_best   <= 1'b1;
            end
          end else if (abort) begin
            state    <= IDLE;
            presc    <= '0;
            overflow <= 1'b0;
          end else if (!hold) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && (time_bcd == TIME_MAX)) overflow <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state    <= RUN;
            presc    <= '0;
            overflow <= 1'b0;
            new_best <= 1'b0;
          end else if (abort) begin
            state    <= IDLE;
            overflow <= 1'b0;
            new_best <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: expected results queued at stop, checked on entry to DONE.
module tb_game_timer;

  logic clk;
  logic rst_n;
  logic start, stop, abort;
  logic [15:0] time_bcd, best_bcd;
  logic best_valid, new_best, running, done, overflow;

  logic start2, stop2;
  logic [15:0] time2, best2;
  logic bv2, nb2, run2, done2, ov2;

`ifdef GAME_TIMER_PAUSE_EN
  logic pause;
`endif

  localparam int DIV = 10;

  game_timer #(.CLK_HZ(100), .TICK_HZ(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .abort(abort),
`ifdef GAME_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .time_bcd(time_bcd), .best_bcd(best_bcd), .best_valid(best_valid),
    .new_best(new_best), .running(running), .done(done), .overflow(overflow)
  );

  // Fast-tick instance (2 cycles per tick) so saturation is reachable quickly.
  game_timer #(.CLK_HZ(20), .TICK_HZ(10)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .abort(1'b0),
`ifdef GAME_TIMER_PAUSE_EN
    .pause(1'b0),
`endif
    .time_bcd(time2), .best_bcd(best2), .best_valid(bv2),
    .new_best(nb2), .running(run2), .done(done2), .overflow(ov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] t;
    logic [15:0] b;
    logic        bv;
    logic        nb;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] bm_best = 16'h9999;
  logic        bm_valid = 1'b0;
  logic        done_q = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_done(input int ticks);
    exp_t e;
    e.t  = to_bcd(ticks);
    e.nb = !bm_valid || (e.t < bm_best);
    if (e.nb) begin
      bm_best  = e.t;
      bm_valid = 1'b1;
    end
    e.b  = bm_best;
    e.bv = bm_valid;
    sb.push_back(e);
  endtask

  // Stop (optionally with abort/start alongside) and wait, bounded, for the monitor.
  task automatic finish_level(input int ticks, input logic with_abort, input logic with_start);
    int k;
    expect_done(ticks);
    stop = 1'b1; abort = with_abort; start = with_start;
    cyc(1);
    stop = 1'b0; abort = 1'b0; start = 1'b0;
    k = 0;
    while (sb.size() > 0 && k < 5) begin
      cyc(1);
      k++;
    end
    if (sb.size() > 0) begin
      check("sb_timeout", 16'(sb.size()), 16'd0);
      sb.delete();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic run_level(input int n, input logic with_abort, input logic with_start);
    pulse_start();
    cyc(n);
    finish_level(n / DIV, with_abort, with_start);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_time"}, time_bcd, 16'h0000);
    check({tag, "_best"}, best_bcd, 16'h9999);
    check({tag, "_flags"}, {11'd0, best_valid, new_best, running, done, overflow}, 16'd0);
  endtask

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_time", time_bcd, e.t);
        check("done_best", best_bcd, e.b);
        check("done_best_valid", {15'd0, best_valid}, {15'd0, e.bv});
        check("done_new_best", {15'd0, new_best}, {15'd0, e.nb});
        check("done_overflow", {15'd0, overflow}, 16'd0);
      end
    end
    done_q = done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0;
    start2 = 1'b0; stop2 = 1'b0;
`ifdef GAME_TIMER_PAUSE_EN
    pause = 1'b0;
`endif
    cyc(2);
    check_reset_state("rst");
    rst_n = 1'b1;
    cyc(50);
    check_reset_state("idle50");

    run_level(125, 1'b0, 1'b0);
    cyc(20);
    check("frozen_time", time_bcd, 16'h0012);
    check("frozen_done", {15'd0, done}, 16'd1);

    run_level(200, 1'b0, 1'b1);  // start+stop: stop wins
    run_level(80, 1'b0, 1'b0);
    run_level(990, 1'b0, 1'b0);
    run_level(1000, 1'b0, 1'b0);
    run_level(80, 1'b0, 1'b0);   // equal to best: no new_best

    pulse_start();
    cyc(55);
    check("pre_abort_time", time_bcd, 16'h0005);
    check("pre_abort_running", {15'd0, running}, 16'd1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("abort_time", time_bcd, 16'h0000);
    check("abort_state", {14'd0, running, done}, 16'd0);
    check("abort_best", best_bcd, bm_best);

    run_level(65, 1'b1, 1'b0);   // stop+abort: stop wins

    start = 1'b1; abort = 1'b1;  // start+abort in DONE: start wins
    cyc(1);
    start = 1'b0; abort = 1'b0;
    check("restart_state", {14'd0, running, done}, 16'd2);
    check("restart_time", time_bcd, 16'h0000);
    check("restart_new_best", {15'd0, new_best}, 16'd0);
    cyc(30);
    finish_level(3, 1'b0, 1'b0);

    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("done_abort_state", {14'd0, running, done}, 16'd0);
    check("done_abort_time", time_bcd, 16'h0000);
    check("done_abort_new_best", {15'd0, new_best}, 16'd0);
    check("done_abort_best", best_bcd, bm_best);

`ifdef GAME_TIMER_PAUSE_EN
    pulse_start();
    cyc(40);
    pause = 1'b1;
    cyc(50);
    pause = 1'b0;
    cyc(35);
    finish_level(75 / DIV, 1'b0, 1'b0);
`endif

    pulse_start();
    cyc(30);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check_reset_state("mid_run_rst");
    bm_best = 16'h9999;
    bm_valid = 1'b0;

    start2 = 1'b1;
    cyc(1);
    start2 = 1'b0;
    cyc(19996);
    check("ovf_pre_time", time2, 16'h9998);
    check("ovf_pre_flag", {15'd0, ov2}, 16'd0);
    cyc(20);
    check("ovf_hold_time", time2, 16'h9999);
    check("ovf_flag", {15'd0, ov2}, 16'd1);
    stop2 = 1'b1;
    cyc(1);
    stop2 = 1'b0;
    check("ovf_done", {14'd0, run2, done2}, 16'd1);
    check("ovf_best", best2, 16'h9999);
    check("ovf_best_flags", {14'd0, bv2, nb2}, 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
